id_ex_operand_stage: RTL

//  ID/EX pipeline register plus EX operand selection. Captures decoded fields from ID, resolves
//  RAW hazards by forwarding from MEM and WB, and drives the final ALU/shifter operands
//  (alu_a = value shifted, alu_b = shift amount or second operand) to the EX-stage ALU.

---
 rtl/id_ex_operand_stage_pkg.sv | 48 ++++
 rtl/id_ex_operand_stage_fwd.sv | 26 ++
 rtl/id_ex_operand_stage.sv | 133 +++++++++++++
 3 files changed

// File: rtl/id_ex_operand_stage_pkg.sv
// Shared constants and types for the ID/EX operand stage: datapath widths, ALU opcodes and the
// EX-side pipeline register layout.
package id_ex_operand_stage_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned OPW  = 4;
  localparam int unsigned RAW  = 5;

  typedef enum logic [OPW-1:0] {
    AluAdd  = 4'd0,
    AluSub  = 4'd1,
    AluAnd  = 4'd2,
    AluOr   = 4'd3,
    AluXor  = 4'd4,
    AluNor  = 4'd5,
    AluSlt  = 4'd6,
    AluSltu = 4'd7,
    AluSll  = 4'd8,
    AluSrl  = 4'd9,
    AluSra  = 4'd10,
    AluLui  = 4'd11
  } alu_op_e;

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic [XLEN-1:0] pc;
    logic [OPW-1:0]  alu_op;
    logic [RAW-1:0]  rd_addr;
    logic [RAW-1:0]  rs_addr;
    logic [RAW-1:0]  rt_addr;
    logic [XLEN-1:0] rs_data;
    logic [XLEN-1:0] rt_data;
    logic [XLEN-1:0] imm;
    logic [RAW-1:0]  shamt;
    logic            is_shift;
    logic            shift_var;
    logic            alu_src_imm;
  } ex_regs_t;

  // Register $0 is hardwired to zero, so it never takes part in a bypass.
  function automatic logic fwd_hit(logic we, logic [RAW-1:0] src, logic [RAW-1:0] dst);
    return we && (src == dst) && (dst != '0);
  endfunction

endpackage

// File: rtl/id_ex_operand_stage_fwd.sv
// Per-operand bypass mux: MEM result beats WB result beats the captured register value.
module id_ex_operand_stage_fwd
  import id_ex_operand_stage_pkg::*;
(
  input  logic            en_i,
  input  logic [RAW-1:0]  reg_addr_i,
  input  logic [XLEN-1:0] reg_data_i,
  input  logic            mem_we_i,
  input  logic [RAW-1:0]  mem_addr_i,
  input  logic [XLEN-1:0] mem_data_i,
  input  logic            wb_we_i,
  input  logic [RAW-1:0]  wb_addr_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic [XLEN-1:0] data_o
);

  always_comb begin
    data_o = reg_data_i;
    if (en_i && fwd_hit(mem_we_i, mem_addr_i, reg_addr_i)) begin
      data_o = mem_data_i;
    end else if (en_i && fwd_hit(wb_we_i, wb_addr_i, reg_addr_i)) begin
      data_o = wb_data_i;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB forwarding, ALU/shifter operand selection and load-use
// hazard detection.
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            id_valid_i,
  input  logic [XLEN-1:0] id_pc_i,
  input  logic [RAW-1:0]  id_rs_addr_i,
  input  logic [RAW-1:0]  id_rt_addr_i,
  input  logic [RAW-1:0]  id_rd_addr_i,
  input  logic [XLEN-1:0] id_rs_data_i,
  input  logic [XLEN-1:0] id_rt_data_i,
  input  logic [XLEN-1:0] id_imm_i,
  input  logic [RAW-1:0]  id_shamt_i,
  input  logic [OPW-1:0]  id_alu_op_i,
  input  logic            id_is_shift_i,
  input  logic            id_shift_var_i,
  input  logic            id_alu_src_imm_i,
  input  logic            id_reg_write_i,
  input  logic            id_mem_read_i,
  input  logic            id_mem_write_i,
  input  logic            mem_fwd_we_i,
  input  logic [RAW-1:0]  mem_fwd_addr_i,
  input  logic [XLEN-1:0] mem_fwd_data_i,
  input  logic            wb_fwd_we_i,
  input  logic [RAW-1:0]  wb_fwd_addr_i,
  input  logic [XLEN-1:0] wb_fwd_data_i,
  output logic            ex_valid_o,
  output logic [XLEN-1:0] ex_pc_o,
  output logic [OPW-1:0]  ex_alu_op_o,
  output logic [RAW-1:0]  ex_rd_addr_o,
  output logic            ex_reg_write_o,
  output logic            ex_mem_read_o,
  output logic            ex_mem_write_o,
  output logic [XLEN-1:0] ex_alu_a_o,
  output logic [XLEN-1:0] ex_alu_b_o,
  output logic [XLEN-1:0] ex_store_data_o,
  output logic            load_use_haz_o
);

  ex_regs_t        ex_d, ex_q;
  logic [XLEN-1:0] fwd_rs, fwd_rt;

  id_ex_operand_stage_fwd u_fwd_rs (
    .en_i       (ex_q.valid),
    .reg_addr_i (ex_q.rs_addr),
    .reg_data_i (ex_q.rs_data),
    .mem_we_i   (mem_fwd_we_i),
    .mem_addr_i (mem_fwd_addr_i),
    .mem_data_i (mem_fwd_data_i),
    .wb_we_i    (wb_fwd_we_i),
    .wb_addr_i  (wb_fwd_addr_i),
    .wb_data_i  (wb_fwd_data_i),
    .data_o     (fwd_rs)
  );

  id_ex_operand_stage_fwd u_fwd_rt (
    .en_i       (ex_q.valid),
    .reg_addr_i (ex_q.rt_addr),
    .reg_data_i (ex_q.rt_data),
    .mem_we_i   (mem_fwd_we_i),
    .mem_addr_i (mem_fwd_addr_i),
    .mem_data_i (mem_fwd_data_i),
    .wb_we_i    (wb_fwd_we_i),
    .wb_addr_i  (wb_fwd_addr_i),
    .wb_data_i  (wb_fwd_data_i),
    .data_o     (fwd_rt)
  );

  always_comb begin
    ex_d = ex_q;
    if (flush_i) begin
      ex_d = '0;
    end else if (stall_i) begin
      // Bank forwarded operands so a producer retiring during the stall is not lost.
      ex_d.rs_data = fwd_rs;
      ex_d.rt_data = fwd_rt;
    end else begin
      ex_d.valid       = id_valid_i;
      ex_d.reg_write   = id_valid_i & id_reg_write_i;
      ex_d.mem_read    = id_valid_i & id_mem_read_i;
      ex_d.mem_write   = id_valid_i & id_mem_write_i;
      ex_d.pc          = id_pc_i;
      ex_d.alu_op      = id_alu_op_i;
      ex_d.rd_addr     = id_rd_addr_i;
      ex_d.rs_addr     = id_rs_addr_i;
      ex_d.rt_addr     = id_rt_addr_i;
      ex_d.rs_data     = id_rs_data_i;
      ex_d.rt_data     = id_rt_data_i;
      ex_d.imm         = id_imm_i;
      ex_d.shamt       = id_shamt_i;
      ex_d.is_shift    = id_is_shift_i;
      ex_d.shift_var   = id_shift_var_i;
      ex_d.alu_src_imm = id_alu_src_imm_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  always_comb begin
    ex_alu_a_o = ex_q.is_shift ? fwd_rt : fwd_rs;
    if (ex_q.is_shift) begin
      ex_alu_b_o = {{(XLEN-RAW){1'b0}}, ex_q.shift_var ? fwd_rs[RAW-1:0] : ex_q.shamt};
    end else if (ex_q.alu_src_imm) begin
      ex_alu_b_o = ex_q.imm;
    end else begin
      ex_alu_b_o = fwd_rt;
    end
  end

  assign ex_store_data_o = fwd_rt;
  assign ex_valid_o      = ex_q.valid;
  assign ex_pc_o         = ex_q.pc;
  assign ex_alu_op_o     = ex_q.alu_op;
  assign ex_rd_addr_o    = ex_q.rd_addr;
  assign ex_reg_write_o  = ex_q.reg_write;
  assign ex_mem_read_o   = ex_q.mem_read;
  assign ex_mem_write_o  = ex_q.mem_write;

  assign load_use_haz_o = ex_q.valid && ex_q.mem_read && (ex_q.rd_addr != '0) && id_valid_i &&
                          ((ex_q.rd_addr == id_rs_addr_i) || (ex_q.rd_addr == id_rt_addr_i));

endmodule
